// File: rtl/dir_button_conditioner_pkg.sv
// Shared definitions for the direction-button conditioner: direction codes
// (matching the movement FSM state encoding), repeat FSM states, priority helper.
package dir_button_conditioner_pkg;

   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;
   localparam logic [3:0] DIR_NONE  = 4'b0000;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DELAY  = 2'd1,
      S_REPEAT = 2'd2
   } rep_state_t;

   // Debounced levels are packed {right,left,down,up}; up has the highest priority.
   function automatic logic [3:0] prio_onehot(input logic [3:0] i_levels);
      logic [3:0] w_dir;
      w_dir = DIR_NONE;
      if (i_levels[0])      w_dir = DIR_UP;
      else if (i_levels[1]) w_dir = DIR_DOWN;
      else if (i_levels[2]) w_dir = DIR_LEFT;
      else if (i_levels[3]) w_dir = DIR_RIGHT;
      return w_dir;
   endfunction

endpackage

// File: rtl/dir_button_conditioner_if.sv
// Button/step bundle between the raw buttons, the conditioner and the movement FSM.
// master: drives the buttons and consumes steps; slave: the conditioner.
interface dir_button_conditioner_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       step;
   logic [3:0] dir;
   logic [3:0] held;

   modport master (
      output btn_up, btn_down, btn_left, btn_right,
      input  step, dir, held
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right,
      output step, dir, held
   );
endinterface

// File: rtl/dir_button_conditioner_debounce_cell.sv
// One raw button: two-flop synchroniser followed by a counter debouncer that
// accepts a new level only after it has differed from the stable one for DEBOUNCE_CYCLES.
module debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 ||
       longint'(DEBOUNCE_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_bad_debounce
      $error("debounce_cell: DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
   end

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign dout = r_stable;

endmodule

// File: rtl/dir_button_conditioner.sv
// Conditions four raw direction buttons into one-hot step strobes with
// keyboard-style auto-repeat for the box-movement FSM.
//
//   state    | meaning
//   S_IDLE   | no direction held; first press fires a step immediately
//   S_DELAY  | step issued, waiting REPEAT_DELAY for the first auto-repeat
//   S_REPEAT | auto-repeating every REPEAT_PERIOD while the direction is held
module dir_button_conditioner
   import dir_button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int CNT_W           = 26
) (
   input  logic                     clk,
   input  logic                     rst,
   dir_button_conditioner_if.slave  bus
);

   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   // Both repeat intervals must be >= 2 so a held direction never steps on back-to-back cycles.
   if (REPEAT_DELAY < 2 ||
       longint'(REPEAT_DELAY - 1) >= (longint'(1) << CNT_W)) begin : g_bad_delay
      $error("dir_button_conditioner: REPEAT_DELAY must be >= 2 and REPEAT_DELAY-1 fit in CNT_W bits");
   end
   if (REPEAT_PERIOD < 2 ||
       longint'(REPEAT_PERIOD - 1) >= (longint'(1) << CNT_W)) begin : g_bad_period
      $error("dir_button_conditioner: REPEAT_PERIOD must be >= 2 and REPEAT_PERIOD-1 fit in CNT_W bits");
   end

   logic [3:0]       w_raw;
   logic [3:0]       w_stable;
   logic [3:0]       r_held;
   rep_state_t       r_state;
   logic [CNT_W-1:0] r_tmr;
   logic             r_step;
   logic [3:0]       r_dir;

   assign w_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

   for (genvar g = 0; g < 4; g++) begin : g_db
      debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_cell (
         .clk  (clk),
         .rst  (rst),
         .din  (w_raw[g]),
         .dout (w_stable[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_held <= DIR_NONE;
      end else begin
         r_held <= prio_onehot(w_stable);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
         r_step  <= 1'b0;
         r_dir   <= DIR_NONE;
      end else begin
         r_step <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_held != DIR_NONE) begin
                  r_step  <= 1'b1;
                  r_dir   <= r_held;
                  r_tmr   <= DELAY_LAST;
                  r_state <= S_DELAY;
               end
            end
            S_DELAY, S_REPEAT: begin
               // Release is checked first so it wins over a simultaneous timer expiry.
               if (r_held == DIR_NONE) begin
                  r_tmr   <= '0;
                  r_state <= S_IDLE;
               end else if (r_held != r_dir) begin
                  r_step  <= 1'b1;
                  r_dir   <= r_held;
                  r_tmr   <= DELAY_LAST;
                  r_state <= S_DELAY;
               end else if (r_tmr == '0) begin
                  r_step  <= 1'b1;
                  r_tmr   <= PERIOD_LAST;
                  r_state <= S_REPEAT;
               end else begin
                  r_tmr <= r_tmr - 1'b1;
               end
            end
            default: begin
               r_tmr   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.step = r_step;
   assign bus.dir  = r_dir;
   assign bus.held = r_held;

endmodule

// File: tb/tb_dir_button_conditioner.sv
// Bench for dir_button_conditioner: cycle-level behavioural model, per-cycle
// compare, directed scenarios with literal pins, then randomized button traffic.
module tb_dir_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] raw = 4'b0000;   // {right,left,down,up}

   int checks   = 0;
   int failures = 0;
   int ecnt     = 0;            // number of rising edges so far
   int n_steps  = 0;

   dir_button_conditioner_if bus();

   assign bus.btn_up    = raw[0];
   assign bus.btn_down  = raw[1];
   assign bus.btn_left  = raw[2];
   assign bus.btn_right = raw[3];

   dir_button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .CNT_W           (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s after edge %0d: got %b expected %b", name, ecnt - 1, act, exp);
      end
   endtask

   // Lowest set bit wins: up, then down, left, right.
   function automatic logic [3:0] first_pressed(input logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return 4'(1 << i);
      return 4'b0000;
   endfunction

   // Model: sampled-input pipeline, run-length debounce, and an absolute
   // "next due edge" schedule for repeats instead of a countdown.
   logic [3:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_held = '0, m_dir = '0;
   logic       m_step = 1'b0, m_active = 1'b0;
   int         m_run [4] = '{0, 0, 0, 0};
   int         m_due = 0;

   always @(posedge clk) begin
      logic [3:0] old_s2, old_stable, old_held;
      old_s2     = m_s2;
      old_stable = m_stable;
      old_held   = m_held;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0; m_held = '0; m_dir = '0;
         m_step = 1'b0; m_active = 1'b0; m_due = 0;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
      end else begin
         m_s2 = m_s1;
         m_s1 = raw;
         for (int i = 0; i < 4; i++) begin
            if (old_s2[i] != old_stable[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == DB) begin
                  m_stable[i] = old_s2[i];
                  m_run[i]    = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_held = first_pressed(old_stable);
         m_step = 1'b0;
         if (old_held == 4'b0000) begin
            m_active = 1'b0;
         end else if (!m_active || old_held != m_dir) begin
            m_step   = 1'b1;
            m_dir    = old_held;
            m_due    = ecnt + RD;
            m_active = 1'b1;
         end else if (ecnt == m_due) begin
            m_step = 1'b1;
            m_due  = ecnt + RP;
         end
      end
      ecnt++;
   end

   logic       prev_step = 1'b0;
   logic [3:0] prev_dir  = '0;

   always @(negedge clk) begin
      if (ecnt > 0) begin
         check("step", {3'b000, bus.step}, {3'b000, m_step});
         check("dir",  bus.dir,  m_dir);
         check("held", bus.held, m_held);
         check("same_dir_back_to_back",
               {3'b000, (bus.step && prev_step && bus.dir == prev_dir)}, 4'b0000);
         if (bus.step) n_steps++;
         prev_step = bus.step;
         prev_dir  = bus.dir;
      end
   end

   task automatic wait_after(input int edge_idx);
      while (ecnt <= edge_idx) @(negedge clk);
   endtask

   task automatic pin_step(input string name, input int edge_idx, input logic [3:0] exp_dir);
      wait_after(edge_idx);
      check(name, {3'b000, bus.step}, 4'b0001);
      check(name, bus.dir, exp_dir);
   endtask

   task automatic pin_nostep(input string name, input int edge_idx);
      wait_after(edge_idx);
      check(name, {3'b000, bus.step}, 4'b0000);
   endtask

   // Leaves the bench at the negedge where rst has just been released; returns the next edge index.
   task automatic do_reset(output int base);
      @(negedge clk);
      raw = 4'b0000;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
      base = ecnt;
   endtask

   initial begin
      int base, n0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_step", {3'b000, bus.step}, 4'b0000);
      check("reset_dir",  bus.dir,  4'b0000);
      check("reset_held", bus.held, 4'b0000);

      // 1: hold up
      do_reset(base);
      raw = 4'b0001;
      pin_nostep("t1_nostep6", base + 6);
      pin_step("t1_first", base + 7, 4'b0001);
      check("t1_held", bus.held, 4'b0001);
      pin_nostep("t1_nostep8", base + 8);
      pin_step("t1_rep17", base + 17, 4'b0001);
      pin_step("t1_rep20", base + 20, 4'b0001);
      pin_step("t1_rep23", base + 23, 4'b0001);

      // 2: 3-cycle glitch on left
      do_reset(base);
      n0  = n_steps;
      raw = 4'b0100;
      wait_after(base + 2);
      raw = 4'b0000;
      wait_after(base + 25);
      check("t2_steps", 4'(n_steps - n0), 4'd0);
      check("t2_held", bus.held, 4'b0000);

      // 3: left held, up added at 20, up released at 40
      do_reset(base);
      raw = 4'b0100;
      pin_step("t3_left", base + 7, 4'b0100);
      wait_after(base + 19);
      raw = 4'b0101;
      pin_step("t3_up", base + 27, 4'b0001);
      check("t3_held_up", bus.held, 4'b0001);
      pin_nostep("t3_restart", base + 30);
      pin_step("t3_up_rep", base + 37, 4'b0001);
      wait_after(base + 39);
      raw = 4'b0100;
      pin_step("t3_back_left", base + 47, 4'b0100);
      check("t3_held_left", bus.held, 4'b0100);

      // 4: short right press, a single step
      do_reset(base);
      n0  = n_steps;
      raw = 4'b1000;
      pin_step("t4_right", base + 7, 4'b1000);
      wait_after(base + 9);
      raw = 4'b0000;
      wait_after(base + 15);
      check("t4_held_before", bus.held, 4'b1000);
      wait_after(base + 16);
      check("t4_held_clear", bus.held, 4'b0000);
      wait_after(base + 35);
      check("t4_steps", 4'(n_steps - n0), 4'd1);
      check("t4_dir_hold", bus.dir, 4'b1000);

      // 5: reset while down is held
      do_reset(base);
      raw = 4'b0010;
      pin_step("t5_first", base + 7, 4'b0010);
      wait_after(base + 11);
      rst = 1'b1;
      wait_after(base + 12);
      check("t5_rst_held", bus.held, 4'b0000);
      check("t5_rst_dir",  bus.dir,  4'b0000);
      wait_after(base + 13);
      rst = 1'b0;
      pin_nostep("t5_nostep20", base + 20);
      pin_step("t5_fresh", base + 21, 4'b0010);

      // 6: release lands on the repeat expiry
      do_reset(base);
      n0  = n_steps;
      raw = 4'b0001;
      pin_step("t6_first", base + 7, 4'b0001);
      wait_after(base + 15);
      raw = 4'b0000;
      pin_step("t6_rep20", base + 20, 4'b0001);
      wait_after(base + 22);
      check("t6_held_clear", bus.held, 4'b0000);
      pin_nostep("t6_expiry", base + 23);
      wait_after(base + 40);
      check("t6_steps", 4'(n_steps - n0), 4'd3);

      // Randomized traffic, occasional reset pulses
      do_reset(base);
      for (int seg = 0; seg < 120; seg++) begin
         int len;
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            rst = 1'b0;
         end
         raw = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         len = $urandom_range(1, 30);
         repeat (len) @(negedge clk);
      end
      raw = 4'b0000;
      repeat (30) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
